// File: rtl/scr1_axi_arb_pkg.sv
// Shared types for the SCR1 AXI read-port arbiter: AR payload record, source tags
// and the AR channel state encoding.
package scr1_axi_arb_pkg;

    localparam logic SRC_S0 = 1'b0;
    localparam logic SRC_S1 = 1'b1;

    // Widest merged ID the payload record can carry; the top truncates to M_IDW.
    localparam int unsigned ARB_ID_MAXW = 8;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

    typedef struct packed {
        logic [ARB_ID_MAXW-1:0] id;
        logic [31:0]            addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
    } ar_pld_t;

endpackage

// File: rtl/scr1_rr_arb2.sv
// Two-way round-robin grant. The pointer names the preferred source and moves to
// the loser whenever a grant is taken.
module scr1_rr_arb2
    import scr1_axi_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;
    logic win;

    always_comb begin
        win = ptr_q;
        if (!req_i[ptr_q]) begin
            win = ~ptr_q;
        end
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o[win] = 1'b1;
        end
        ptr_d = ptr_q;
        if (accept_i && (|req_i)) begin
            ptr_d = ~win;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= SRC_S0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scr1_axi_rd_arbiter.sv
// Merges the SCR1 IMEM (S0) and DMEM (S1) AXI4 read masters onto one read port,
// tagging the ID MSB with the source and routing R beats back by that tag.
module scr1_axi_rd_arbiter
    import scr1_axi_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned S0_IDW    = 3,
    parameter int unsigned S1_IDW    = 2,
    parameter int unsigned M_IDW     = 4
) (
    input  logic              clk_riscv,
    input  logic              reset,
    input  logic [S0_IDW-1:0] s0_arid,
    input  logic [31:0]       s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [S0_IDW-1:0] s0_rid,
    output logic [31:0]       s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    input  logic [S1_IDW-1:0] s1_arid,
    input  logic [31:0]       s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [S1_IDW-1:0] s1_rid,
    output logic [31:0]       s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [M_IDW-1:0]  m_arid,
    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [M_IDW-1:0]  m_rid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              busy
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and payload is held stable while valid is up.

    ar_state_e          state_q;
    ar_pld_t            ar_q;
    logic               m_arvalid_q;
    logic [1:0][CW-1:0] cnt_q;
    logic [1:0][CW-1:0] cnt_d;

    logic [1:0] elig;
    logic [1:0] req;
    logic [1:0] gnt;
    ar_pld_t    pld0;
    ar_pld_t    pld1;
    logic       r_src;
    logic [1:0] r_sel;
    logic       r_last_hs;
    logic [1:0] r_dec;

    assign elig[0] = s0_arvalid && (cnt_q[0] < CW'(MAX_OUTST));
    assign elig[1] = s1_arvalid && (cnt_q[1] < CW'(MAX_OUTST));
    assign req     = (state_q == AR_IDLE) ? elig : 2'b00;

    scr1_rr_arb2 u_rr (
        .clk_i    (clk_riscv),
        .rst_i    (reset),
        .req_i    (req),
        .accept_i (state_q == AR_IDLE),
        .gnt_o    (gnt)
    );

    assign s0_arready = gnt[0];
    assign s1_arready = gnt[1];

    assign pld0 = '{id:    ARB_ID_MAXW'({SRC_S0, (M_IDW-1)'(s0_arid)}),
                    addr:  s0_araddr, len: s0_arlen, size: s0_arsize, burst: s0_arburst};
    assign pld1 = '{id:    ARB_ID_MAXW'({SRC_S1, (M_IDW-1)'(s1_arid)}),
                    addr:  s1_araddr, len: s1_arlen, size: s1_arsize, burst: s1_arburst};

    // No bypass: an accepted request always spends one cycle in the payload register.
    always_ff @(posedge clk_riscv or posedge reset) begin
        if (reset) begin
            state_q     <= AR_IDLE;
            ar_q        <= '0;
            m_arvalid_q <= 1'b0;
        end else begin
            case (state_q)
                AR_IDLE: begin
                    if (|gnt) begin
                        state_q     <= AR_HOLD;
                        ar_q        <= gnt[1] ? pld1 : pld0;
                        m_arvalid_q <= 1'b1;
                    end
                end
                AR_HOLD: begin
                    if (m_arready) begin
                        state_q     <= AR_IDLE;
                        m_arvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= AR_IDLE;
                    m_arvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_arvalid = m_arvalid_q;
    assign m_arid    = M_IDW'(ar_q.id);
    assign m_araddr  = ar_q.addr;
    assign m_arlen   = ar_q.len;
    assign m_arsize  = ar_q.size;
    assign m_arburst = ar_q.burst;

    assign r_src     = m_rid[M_IDW-1];
    assign r_sel     = {r_src, ~r_src};
    assign m_rready  = r_src ? s1_rready : s0_rready;
    assign r_last_hs = m_rvalid && m_rready && m_rlast;

    assign s0_rvalid = m_rvalid && !r_src;
    assign s1_rvalid = m_rvalid && r_src;
    assign s0_rid    = m_rid[S0_IDW-1:0];
    assign s1_rid    = m_rid[S1_IDW-1:0];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;

    // A last beat for a source with nothing outstanding is dropped from the count.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            r_dec[n] = r_last_hs && r_sel[n] && (cnt_q[n] != '0);
            cnt_d[n] = cnt_q[n];
            if (gnt[n] && !r_dec[n]) begin
                cnt_d[n] = cnt_q[n] + CW'(1);
            end else if (!gnt[n] && r_dec[n]) begin
                cnt_d[n] = cnt_q[n] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_riscv or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (state_q == AR_HOLD) || (cnt_q[0] != '0) || (cnt_q[1] != '0);

    a_no_orphan_rlast : assert property (@(posedge clk_riscv) disable iff (reset)
        r_last_hs |-> (cnt_q[r_src] != '0))
        else $error("R last beat with no outstanding burst for source %0d", r_src);

endmodule
